// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard controller. It keeps a per-register scoreboard of
//            in-flight writes (wcnt) and loads (lcnt), and uses it to detect
//            data hazards and branch-target hazards. A small FSM sequences
//            branch flushes and the second byte of two-byte instructions.
//
// Build option:
//            HAZARD_CTRL_FWD_EN - when defined, forwarding exists, so only
//            load-use hazards stall (lcnt). When undefined, every RAW hazard
//            stalls until writeback (wcnt), and the lcnt logic is not built.
//
// Ports    : clk, rst            - clock, synchronous active-high reset
//            id_valid            - ID stage holds a real instruction
//            id_opcode           - ID opcode (4 bits)
//            id_ra, id_rb        - ID source registers
//            id_uses_ra/rb       - the source is actually read
//            id_rd               - ID destination register
//            id_reg_write        - ID instruction writes a register
//            id_mem_read         - ID instruction is a load
//            branch_take         - branch resolved taken this cycle
//            pc_en, if_id_en     - PC / IF-ID register enables
//            flush               - squash IF/ID
//            bubble              - insert a NOP into ID/EX
//            busy                - some write is still in flight
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int          REG_W     = 2,
    parameter int          WB_LAT    = 3,
    parameter int          LOAD_LAT  = 1,
    parameter int          FLUSH_CYC = 1,
    parameter logic [15:0] BR_MASK   = 16'h0E00,
    parameter logic [3:0]  OP_2B     = 4'd12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [3:0]       id_opcode,
    input  logic [REG_W-1:0] id_ra,
    input  logic [REG_W-1:0] id_rb,
    input  logic             id_uses_ra,
    input  logic             id_uses_rb,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             branch_take,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             flush,
    output logic             bubble,
    output logic             busy
);

    localparam int         c_NREG        = 1 << REG_W;
    localparam logic [2:0] c_WB_LAT      = 3'(WB_LAT);
    localparam logic [2:0] c_LOAD_LAT    = 3'(LOAD_LAT);
    localparam logic [1:0] c_FLUSH_RLD   = 2'(FLUSH_CYC - 1);
    localparam bit         c_MULTI_FLUSH = (FLUSH_CYC > 1);

    localparam logic [1:0] c_ST_RUN   = 2'd0;
    localparam logic [1:0] c_ST_FLUSH = 2'd1;
    localparam logic [1:0] c_ST_OPND  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [1:0]        r_fcnt;
    logic [1:0]        w_fcnt_nxt;
    logic [2:0]        r_wcnt [c_NREG];
    logic [c_NREG-1:0] w_wnz;
    logic [c_NREG-1:0] w_wload;
    logic              w_pend_a;
    logic              w_pend_b;
    logic              w_br_haz;
    logic              w_stall;
    logic              w_issue;

    // Per-register decode: reload strobe and "write still in flight" flag.
    for (genvar g = 0; g < c_NREG; g++) begin : g_reg
        assign w_wload[g] = w_issue && id_reg_write && (id_rd == REG_W'(g));
        assign w_wnz[g]   = (r_wcnt[g] != 3'd0);
    end

    // Write scoreboard: a reload wins over the same-cycle decrement.
    always_ff @(posedge clk) begin
        for (int r = 0; r < c_NREG; r++) begin
            if (rst) begin
                r_wcnt[r] <= 3'd0;
            end else if (w_wload[r]) begin
                r_wcnt[r] <= c_WB_LAT;
            end else if (r_wcnt[r] != 3'd0) begin
                r_wcnt[r] <= r_wcnt[r] - 3'd1;
            end
        end
    end

`ifdef HAZARD_CTRL_FWD_EN
    logic [2:0] r_lcnt [c_NREG];

    always_ff @(posedge clk) begin
        for (int r = 0; r < c_NREG; r++) begin
            if (rst) begin
                r_lcnt[r] <= 3'd0;
            end else if (w_wload[r] && id_mem_read) begin
                r_lcnt[r] <= c_LOAD_LAT;
            end else if (r_lcnt[r] != 3'd0) begin
                r_lcnt[r] <= r_lcnt[r] - 3'd1;
            end
        end
    end

    // Forwarding covers ALU results; only a load still in flight blocks.
    assign w_pend_a = id_uses_ra && (r_lcnt[id_ra] != 3'd0);
    assign w_pend_b = id_uses_rb && (r_lcnt[id_rb] != 3'd0);
`else
    // Without forwarding, any outstanding write blocks its readers.
    assign w_pend_a = id_uses_ra && w_wnz[id_ra];
    assign w_pend_b = id_uses_rb && w_wnz[id_rb];

    logic w_unused_fwd;
    assign w_unused_fwd = ^{id_mem_read, c_LOAD_LAT};
`endif

    // Branch targets come straight from the register file, never forwarded.
    assign w_br_haz = BR_MASK[id_opcode] && w_wnz[id_rb];
    assign w_stall  = id_valid && (w_pend_a || w_pend_b || w_br_haz) && !branch_take;
    assign w_issue  = id_valid && !w_stall && !flush && (r_state != c_ST_OPND);
    assign busy     = !rst && (|w_wnz);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_RUN;
            r_fcnt  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        case (r_state)
            c_ST_RUN, c_ST_OPND: begin
                // A taken branch outranks leaving OPND or entering it.
                if (branch_take) begin
                    if (c_MULTI_FLUSH) begin
                        w_state_nxt = c_ST_FLUSH;
                        w_fcnt_nxt  = c_FLUSH_RLD;
                    end else begin
                        w_state_nxt = c_ST_RUN;
                    end
                end else if (r_state == c_ST_OPND) begin
                    w_state_nxt = c_ST_RUN;
                end else if (w_issue && (id_opcode == OP_2B)) begin
                    w_state_nxt = c_ST_OPND;
                end
            end
            c_ST_FLUSH: begin
                if (branch_take) begin
                    w_fcnt_nxt = c_FLUSH_RLD;
                end else if (r_fcnt <= 2'd1) begin
                    w_state_nxt = c_ST_RUN;
                    w_fcnt_nxt  = 2'd0;
                end else begin
                    w_fcnt_nxt = r_fcnt - 2'd1;
                end
            end
            default: begin
                w_state_nxt = c_ST_RUN;
                w_fcnt_nxt  = 2'd0;
            end
        endcase
    end

    always_comb begin
        pc_en    = 1'b1;
        if_id_en = 1'b1;
        flush    = 1'b0;
        bubble   = 1'b0;
        if (rst) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            flush    = 1'b1;
        end else if (branch_take || (r_state == c_ST_FLUSH)) begin
            flush = 1'b1;
        end else if (w_stall) begin
            pc_en    = 1'b0;
            if_id_en = 1'b0;
            bubble   = 1'b1;
        end else if (r_state == c_ST_OPND) begin
            // Second byte passes through ID as operand, not as an instruction.
            bubble = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Self-checking bench for hazard_ctrl. Directed scenarios followed
//            by random stimulus, all compared every cycle against a model that
//            tracks, per register, the cycle at which its result becomes
//            readable, plus the last cycle of the current flush window.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int          c_REG_W     = 2;
    localparam int          c_NREG      = 4;
    localparam int          c_WB_LAT    = 3;
    localparam int          c_LOAD_LAT  = 2;
    localparam int          c_FLUSH_CYC = 3;
    localparam logic [15:0] c_BR_MASK   = 16'h0E00;
    localparam logic [3:0]  c_OP_2B     = 4'd12;

    logic         clk = 1'b0;
    logic         rst;
    logic         id_valid;
    logic [3:0]   id_opcode;
    logic [1:0]   id_ra;
    logic [1:0]   id_rb;
    logic         id_uses_ra;
    logic         id_uses_rb;
    logic [1:0]   id_rd;
    logic         id_reg_write;
    logic         id_mem_read;
    logic         branch_take;
    logic         pc_en;
    logic         if_id_en;
    logic         flush;
    logic         bubble;
    logic         busy;

    hazard_ctrl #(
        .REG_W     (c_REG_W),
        .WB_LAT    (c_WB_LAT),
        .LOAD_LAT  (c_LOAD_LAT),
        .FLUSH_CYC (c_FLUSH_CYC),
        .BR_MASK   (c_BR_MASK),
        .OP_2B     (c_OP_2B)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_opcode    (id_opcode),
        .id_ra        (id_ra),
        .id_rb        (id_rb),
        .id_uses_ra   (id_uses_ra),
        .id_uses_rb   (id_uses_rb),
        .id_rd        (id_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .branch_take  (branch_take),
        .pc_en        (pc_en),
        .if_id_en     (if_id_en),
        .flush        (flush),
        .bubble       (bubble),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state: cycle numbers at which things end.
    int wr_ready [c_NREG];
    int ld_ready [c_NREG];
    int flush_end;
    int opnd_at;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit wpend(input logic [1:0] r);
        return wr_ready[r] > cyc;
    endfunction

    function automatic bit dpend(input logic [1:0] r);
`ifdef HAZARD_CTRL_FWD_EN
        return ld_ready[r] > cyc;
`else
        return wr_ready[r] > cyc;
`endif
    endfunction

    task automatic drive(input bit v, input int op, input int ra, input int rb,
                         input bit ura, input bit urb, input int rd,
                         input bit rw, input bit mr, input bit bt);
        id_valid     = v;
        id_opcode    = 4'(op);
        id_ra        = 2'(ra);
        id_rb        = 2'(rb);
        id_uses_ra   = ura;
        id_uses_rb   = urb;
        id_rd        = 2'(rd);
        id_reg_write = rw;
        id_mem_read  = mr;
        branch_take  = bt;
    endtask

    // Inputs are already applied (posedge + 1); check at posedge + 4, then
    // advance the model across the coming edge.
    task automatic tick();
        bit   pend_any, data_h, br_h, stall, in_flush, in_opnd, issue;
        logic e_pc, e_ifid, e_fl, e_bub, e_busy;
        #3;
        pend_any = 1'b0;
        for (int r = 0; r < c_NREG; r++) if (wr_ready[r] > cyc) pend_any = 1'b1;
        data_h   = (id_uses_ra && dpend(id_ra)) || (id_uses_rb && dpend(id_rb));
        br_h     = c_BR_MASK[id_opcode] && wpend(id_rb);
        in_flush = (cyc <= flush_end);
        in_opnd  = (cyc == opnd_at);
        stall    = id_valid && (data_h || br_h) && !branch_take;
        if (rst) begin
            {e_pc, e_ifid, e_fl, e_bub} = 4'b0010;
        end else if (branch_take || in_flush) begin
            {e_pc, e_ifid, e_fl, e_bub} = 4'b1110;
        end else if (stall) begin
            {e_pc, e_ifid, e_fl, e_bub} = 4'b0001;
        end else if (in_opnd) begin
            {e_pc, e_ifid, e_fl, e_bub} = 4'b1101;
        end else begin
            {e_pc, e_ifid, e_fl, e_bub} = 4'b1100;
        end
        e_busy = !rst && pend_any;
        issue  = !rst && id_valid && !stall && !e_fl && !in_opnd;

        chk("pc_en",    pc_en,    e_pc);
        chk("if_id_en", if_id_en, e_ifid);
        chk("flush",    flush,    e_fl);
        chk("bubble",   bubble,   e_bub);
        chk("busy",     busy,     e_busy);

        if (rst) begin
            for (int r = 0; r < c_NREG; r++) begin
                wr_ready[r] = 0;
                ld_ready[r] = 0;
            end
            flush_end = -1;
            opnd_at   = -1;
        end else begin
            if (issue && id_reg_write) begin
                wr_ready[id_rd] = cyc + 1 + c_WB_LAT;
                if (id_mem_read) ld_ready[id_rd] = cyc + 1 + c_LOAD_LAT;
            end
            if (branch_take) flush_end = cyc + c_FLUSH_CYC - 1;
            if (issue && (id_opcode == c_OP_2B)) opnd_at = cyc + 1;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int r = 0; r < c_NREG; r++) begin
            wr_ready[r] = 0;
            ld_ready[r] = 0;
        end
        flush_end = -1;
        opnd_at   = -1;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        // Reset, then first cycle after release
        tick();
        tick();
        rst = 1'b0;
        tick();

        // ALU write to r2, then a reader of r2 held while stalled
        drive(1, 0, 0, 0, 0, 0, 2, 1, 0, 0); tick();
        drive(1, 1, 2, 0, 1, 0, 1, 1, 0, 0); repeat (5) tick();

        // JMP through r3 while r3 is still being written
        drive(1, 0, 0, 0, 0, 0, 3, 1, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 11, 0, 3, 0, 1, 0, 0, 0, 0); repeat (4) tick();

        // Load to r1 followed by a use of r1
        drive(1, 2, 0, 0, 0, 0, 1, 1, 1, 0); tick();
        drive(1, 1, 1, 0, 1, 0, 0, 1, 0, 0); repeat (4) tick();

        // Taken branch, second taken branch two cycles later
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); repeat (4) tick();

        // Two-byte instruction, branch taken during its operand cycle
        drive(1, 12, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); repeat (3) tick();

        // Two-byte instruction without interference
        drive(1, 12, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0); repeat (2) tick();

        // Reset in the middle of a flush while a write is in flight
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); tick();
        rst = 1'b1; tick();
        rst = 1'b0; repeat (2) tick();

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 5) == 0) ? 12 : int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 149) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
